// File: rtl/cassette_fsk_tx.sv
// rtl/cassette_fsk_tx.sv - FSK cassette-tape transmitter with frame FIFO
//
// Queues BITS-wide frames and serialises them as a tape square wave. A phase
// accumulator sets the tick rate. Each bit lasts four ticks. A 1 bit toggles
// every tick (two cycles per bit) and a 0 bit toggles every two ticks (one
// cycle per bit).
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous, active-high; clears FIFO and transmitter
//   step     - phase-accumulator increment, sampled every cycle
//   in_valid - in_data holds a frame to queue
//   in_data  - frame to transmit (BITS wide)
//   in_ready - FIFO can accept a frame (low while full or during abort)
//   abort    - synchronous flush of FIFO and transmitter
//   dout     - tape square wave, 1 while idle
//   busy     - transmitter is not idle
//   done     - one-cycle pulse when the last queued frame has been sent
//
// Build option: define CASSETTE_FSK_TX_LEADER_EN to add a leader before
// every burst. A burst is a run of frames that starts from idle. The leader
// is LEADER_LEN frames with the odd-numbered bits set (0xAA for 8 bits).
module cassette_fsk_tx #(
  parameter int ACC_W      = 24,
  parameter int BITS       = 8,
  parameter int FIFO_LOG2  = 2,
  parameter int MSB_FIRST  = 0,
  parameter int LEADER_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] step,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;

`ifdef CASSETTE_FSK_TX_LEADER_EN
  localparam logic [1:0] S_LEADER = 2'd2;
  localparam int LEADER_FRAMES = LEADER_LEN;
  localparam int LCNT_W = (LEADER_LEN > 1) ? $clog2(LEADER_LEN) : 1;
  localparam logic [LCNT_W-1:0] LEAD_LAST = LCNT_W'((LEADER_LEN > 0) ? LEADER_LEN - 1 : 0);

  function automatic logic [BITS-1:0] leader_pattern();
    logic [BITS-1:0] p;
    p = '0;
    for (int i = 0; i < BITS; i++) begin
      p[i] = ((i % 2) == 1);
    end
    return p;
  endfunction

  localparam logic [BITS-1:0] LEAD_PAT = leader_pattern();

  logic [LCNT_W-1:0] lead_cnt;
`else
  // Without the leader build, LEADER_LEN has no effect on behaviour.
  localparam int LEADER_FRAMES = 0 * LEADER_LEN;
`endif

  logic [BITS-1:0]    fifo_mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr;
  logic [FIFO_LOG2:0] rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [BITS-1:0]    fifo_head;

  logic [1:0]         state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     acc_sum;
  logic [1:0]         cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [BITS-1:0]    shreg;
  logic [BITS-1:0]    shreg_next;
  logic               tick;
  logic               frame_end;
  logic               cur_bit;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[FIFO_LOG2-1:0]];
  assign in_ready   = !fifo_full && !abort;
  assign push       = in_valid && in_ready;

  // The carry out of this cycle's addition is the tick. It acts on the same
  // edge that stores the new accumulator value.
  assign acc_sum    = {1'b0, acc} + {1'b0, step};
  assign tick       = acc_sum[ACC_W];
  assign frame_end  = (state != S_IDLE) && tick && (cnt == 2'd3) && (bit_idx == LAST_IDX);
  assign cur_bit    = (MSB_FIRST != 0) ? shreg[BITS-1] : shreg[0];
  assign shreg_next = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  assign busy = (state != S_IDLE);
  assign dout = (state == S_IDLE) ? 1'b1 : (cur_bit ? ~cnt[0] : ~cnt[1]);

  always_comb begin
    pop = 1'b0;
    if (!abort) begin
      case (state)
        S_IDLE:   pop = !fifo_empty && (LEADER_FRAMES == 0);
        S_DATA:   pop = frame_end && !fifo_empty;
`ifdef CASSETTE_FSK_TX_LEADER_EN
        S_LEADER: pop = frame_end && (lead_cnt == LEAD_LAST);
`endif
        default:  pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_LOG2-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      done     <= 1'b0;
`ifdef CASSETTE_FSK_TX_LEADER_EN
      lead_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        state    <= S_IDLE;
        acc      <= '0;
        cnt      <= '0;
        bit_idx  <= '0;
`ifdef CASSETTE_FSK_TX_LEADER_EN
        lead_cnt <= '0;
`endif
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case (state)
          S_IDLE: begin
            // The accumulator holds while idle. Each burst starts from phase 0.
            if (!fifo_empty) begin
              acc     <= '0;
              cnt     <= '0;
              bit_idx <= '0;
`ifdef CASSETTE_FSK_TX_LEADER_EN
              if (LEADER_FRAMES != 0) begin
                state    <= S_LEADER;
                shreg    <= LEAD_PAT;
                lead_cnt <= '0;
              end else begin
                state <= S_DATA;
                shreg <= fifo_head;
              end
`else
              state <= S_DATA;
              shreg <= fifo_head;
`endif
            end
          end
          default: begin
            // Leader and data frames share the same bit timing.
            acc <= acc_sum[ACC_W-1:0];
            if (tick) begin
              cnt <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                if (bit_idx != LAST_IDX) begin
                  bit_idx <= bit_idx + 1'b1;
                  shreg   <= shreg_next;
                end else begin
                  bit_idx <= '0;
`ifdef CASSETTE_FSK_TX_LEADER_EN
                  if (state == S_LEADER) begin
                    if (lead_cnt == LEAD_LAST) begin
                      state <= S_DATA;
                      shreg <= fifo_head;
                    end else begin
                      lead_cnt <= lead_cnt + 1'b1;
                      shreg    <= LEAD_PAT;
                    end
                  end else if (!fifo_empty) begin
                    shreg <= fifo_head;
                  end else begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                  end
`else
                  // The accumulator keeps running into the next frame, so
                  // back-to-back frames have no gap ticks.
                  if (!fifo_empty) begin
                    shreg <= fifo_head;
                  end else begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                  end
`endif
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cassette_fsk_tx.sv
// tb/tb_cassette_fsk_tx.sv - self-checking bench for cassette_fsk_tx
module tb_cassette_fsk_tx;

  localparam int ACC_W = 8;
  localparam int BITS  = 8;
  localparam int LEN   = 2;
`ifdef CASSETTE_FSK_TX_LEADER_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif
  // With step = 64 a tick arrives every 4 cycles, a bit every 16 cycles and a frame every 128.
  localparam int FRAME_CYC = 128;
  localparam int LEAD_CYC  = LEAD ? LEN * FRAME_CYC : 0;

  logic             clk = 1'b0;
  logic             reset;
  logic [ACC_W-1:0] step;
  logic             in_valid, abort, in_ready, dout, busy, done;
  logic [BITS-1:0]  in_data;
  logic             m_valid, m_abort, m_ready, m_dout, m_busy, m_done;
  logic [BITS-1:0]  m_data;

  int tests = 0;
  int fails = 0;
  int cyc_count = 0;
  int done_cyc = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  cassette_fsk_tx #(.ACC_W(ACC_W), .BITS(BITS), .FIFO_LOG2(2), .MSB_FIRST(0), .LEADER_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .step(step), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .dout(dout), .busy(busy), .done(done));

  cassette_fsk_tx #(.ACC_W(ACC_W), .BITS(BITS), .FIFO_LOG2(2), .MSB_FIRST(1), .LEADER_LEN(LEN)) dut_m (
    .clk(clk), .reset(reset), .step(step), .in_valid(m_valid), .in_data(m_data),
    .in_ready(m_ready), .abort(m_abort), .dout(m_dout), .busy(m_busy), .done(m_done));

  // Reference model for the LSB-first instance. Progress is the total tick
  // count since the burst began (phase / 2**ACC_W). That count is split into
  // frame, bit and quarter-bit positions.
  logic [BITS-1:0] q[$];
  bit              m_act;
  bit              m_lead_cur;
  int              lead_left;
  longint          phase;
  longint          base;
  logic [BITS-1:0] cur;
  bit              exp_done;
  int              m_entry;

  task automatic model_reset();
    q.delete();
    m_act = 0;
    exp_done = 0;
    phase = 0;
    base = 0;
  endtask

  task automatic model_edge();
    bit pushing;
    exp_done = 0;
    pushing = in_valid && !abort && (q.size() < 4);
    if (abort) begin
      q.delete();
      m_act = 0;
    end else begin
      if (!m_act) begin
        if (q.size() > 0) begin
          m_act = 1;
          phase = 0;
          base = 0;
          m_entry = cyc_count;
          if (LEAD) begin
            cur = 8'hAA;
            m_lead_cur = 1;
            lead_left = LEN - 1;
          end else begin
            cur = q.pop_front();
            m_lead_cur = 0;
          end
        end
      end else begin
        phase += longint'(step);
        if ((phase >> ACC_W) - base == 4 * BITS) begin
          base += 4 * BITS;
          if (m_lead_cur && lead_left > 0) begin
            lead_left--;
            cur = 8'hAA;
          end else if (q.size() > 0) begin
            cur = q.pop_front();
            m_lead_cur = 0;
          end else begin
            m_act = 0;
            exp_done = 1;
          end
        end
      end
      if (pushing) q.push_back(in_data);
    end
  endtask

  function automatic logic exp_dout();
    longint t;
    int b, c;
    if (!m_act) return 1'b1;
    t = (phase >> ACC_W) - base;
    b = int'(t / 4);
    c = int'(t % 4);
    return cur[b] ? (c % 2 == 0) : (c < 2);
  endfunction

  // Expected MSB-first waveform n cycles after the burst starts, at step = 64.
  function automatic logic msb_exp(int n);
    int b, c, pos;
    logic [7:0] fr;
    b = n / 16;
    c = (n / 4) % 4;
    fr = (LEAD && b < LEN * 8) ? 8'hAA : 8'h80;
    pos = 7 - (b % 8);
    return fr[pos] ? (c % 2 == 0) : (c < 2);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    #1;
    cyc_count++;
    if (reset) model_reset();
    else model_edge();
    chk({tag, ":dout"}, dout, exp_dout());
    chk({tag, ":busy"}, busy, m_act);
    chk({tag, ":done"}, done, exp_done);
    chk({tag, ":in_ready"}, in_ready, (q.size() < 4) && !abort);
    if (done) begin
      done_cyc = cyc_count;
      n_done++;
    end
  endtask

  task automatic push(logic [BITS-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 3000; i++) begin
      ok = in_ready;
      cyc("push");
      if (ok) break;
    end
    in_valid = 0;
    chk("push:accepted", ok, 1);
  endtask

  task automatic run_frames(string tag, int budget, int exp_lat);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(tag);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({tag, ":finished"}, got, 1);
    if (exp_lat >= 0) chk({tag, ":latency"}, done_cyc - m_entry, exp_lat);
  endtask

  task automatic wait_rel(int target);
    for (int i = 0; i < 5000; i++) begin
      if (cyc_count - m_entry >= target) break;
      cyc("wait");
    end
  endtask

  initial begin
    int d0;
    int nf;
    bit got;
    logic frz;
    reset = 1; step = 8'd64; in_valid = 0; in_data = '0; abort = 0;
    m_valid = 0; m_data = '0; m_abort = 0;
    model_reset();
    m_entry = 0;
    repeat (2) cyc("reset");
    reset = 0;
    chk("post_reset:in_ready", in_ready, 1);

    // One frame 0x01, pushed on the first edge after reset.
    push(8'h01);
    run_frames("single_01", 600, FRAME_CYC + LEAD_CYC);

    // An all-zero frame. In the leader build this also covers the leader.
    push(8'h00);
    run_frames("zero_frame", 1200, FRAME_CYC + LEAD_CYC);

    // Five pushes fill the four-deep FIFO. The frames then play back-to-back.
    d0 = n_done;
    push(8'h0F);
    push(8'hF0);
    for (int k = 0; k < 3; k++) push(BITS'($urandom));
    chk("full:in_ready", in_ready, 0);
    run_frames("b2b", 5000, 5 * FRAME_CYC + LEAD_CYC);
    repeat (20) cyc("b2b_tail");
    chk("b2b:single_done", n_done - d0, 1);

    // Stall mid-frame with step = 0 for 100 cycles.
    push(BITS'($urandom));
    repeat (40) cyc("stall_pre");
    step = 8'd0;
    frz = exp_dout();
    for (int i = 0; i < 100; i++) begin
      cyc("stall");
      chk("stall:frozen", dout, frz);
    end
    step = 8'd64;
    run_frames("stall_resume", 1200, FRAME_CYC + 100 + LEAD_CYC);

    // MSB-first instance, frame 0x80.
    m_valid = 1;
    m_data = 8'h80;
    chk("msb:in_ready", m_ready, 1);
    cyc("msb_push");
    m_valid = 0;
    got = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc("msb");
      if (m_done) begin
        got = 1;
        chk("msb:latency", n, FRAME_CYC + LEAD_CYC);
        break;
      end
      chk("msb:dout", m_dout, msb_exp(n));
    end
    chk("msb:finished", got, 1);

    // Reset in the middle of bit 3 of 0x55, with two frames queued.
    push(8'h55);
    push(8'hA3);
    push(8'h3C);
    wait_rel(LEAD_CYC + 56);
    chk("pre_reset:busy", busy, 1);
    reset = 1;
    #1;
    chk("async_reset:dout", dout, 1);
    chk("async_reset:busy", busy, 0);
    chk("async_reset:done", done, 0);
    model_reset();
    repeat (2) cyc("reset_hold");
    reset = 0;
    d0 = n_done;
    repeat (10) cyc("after_reset");
    chk("after_reset:flushed", busy, 0);
    chk("after_reset:no_done", n_done - d0, 0);

    // Abort at the same point, with a push attempted in the same cycle.
    push(8'h55);
    push(8'hA3);
    push(8'h3C);
    wait_rel(LEAD_CYC + 56);
    abort = 1;
    in_valid = 1;
    in_data = 8'hFF;
    #1;
    chk("abort:in_ready", in_ready, 0);
    d0 = n_done;
    cyc("abort");
    chk("abort:busy", busy, 0);
    chk("abort:dout", dout, 1);
    abort = 0;
    in_valid = 0;
    repeat (10) cyc("after_abort");
    chk("after_abort:idle", busy, 0);
    chk("after_abort:no_done", n_done - d0, 0);

    // Random rates and frame counts.
    for (int r = 0; r < 6; r++) begin
      step = ACC_W'($urandom_range(32, 255));
      nf = $urandom_range(1, 5);
      for (int k = 0; k < nf; k++) push(BITS'($urandom));
      run_frames("random", 9000, -1);
      repeat (3) cyc("random_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
